game_status_ctrl: RTL and testbench
===================================

Name: game_status_ctrl

Overview:
Game-flow controller that produces the 3-bit one-hot Game_status bus consumed by the VGA start/play/end screen selector. It debounces the player's start key and tracks snake collision events. It sequences START -> PLAY -> END -> START, enforcing a minimum end-screen hold time. It also issues a one-cycle reinitialisation pulse to the snake/score logic on every entry to PLAY.

Parameters:
DEBOUNCE_CYCLES, 800000, cycles the synchronised key level must stay unchanged before it is accepted (20 ms at 40 MHz)
END_HOLD_CYCLES, 80000000, minimum cycles in END before a key press is honoured (2 s at 40 MHz)
CNT_W, 27, width of the debounce and hold counters; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, END_HOLD_CYCLES)

Ports:
Clk_40mhz  input  1  system clock, 40 MHz
RSTn  input  1  reset, asynchronous, active-low
key_start_n  input  1  raw start push-button, active-low, asynchronous to Clk_40mhz, bouncy
hit_wall  input  1  single-cycle pulse from snake logic: head left the playfield (synchronous)
hit_body  input  1  single-cycle pulse from snake logic: head hit own body (synchronous)
Game_status  output  3  one-hot state: START=001, PLAY=010, END=100 (registered)
game_rst_pulse  output  1  one-cycle pulse on the first cycle Game_status==PLAY (registered)
key_press  output  1  one-cycle debounced press strobe, exposed for score/debug (registered)

Behaviour:
- Reset (RSTn=0, takes effect immediately, asynchronous):
  - Game_status=001, game_rst_pulse=0, key_press=0.
  - Both synchroniser flops=1, stable key level=1.
  - Debounce counter=0, hold counter=0.
- Synchroniser: 2-flop chain on key_start_n; key_sync is the second flop.
- Debounce:
  - While key_sync==stable_level, the counter holds 0.
  - While they differ, the counter increments each cycle.
  - When the counter==DEBOUNCE_CYCLES-1 and they still differ, stable_level<=key_sync and the counter<=0.
  - A single-cycle mismatch glitch resets the counter to 0 the cycle after the mismatch ends.
- key_press: registered; asserted exactly one cycle, the cycle after stable_level transitions 1->0. A release (0->1) produces no strobe.
- Latency: a clean key edge produces key_press 2 (sync) + DEBOUNCE_CYCLES + 1 cycles later.
- FSM (state register drives Game_status directly; a transition occurs on the edge where the condition is sampled high):
  - START: key_press -> PLAY. hit_wall/hit_body are ignored.
  - PLAY: (hit_wall|hit_body) -> END. key_press is ignored. A hit and a key_press in the same cycle -> END.
  - END: the hold counter increments from 0 each cycle and saturates at END_HOLD_CYCLES-1 (hold_done). key_press with hold_done=1 -> START; key_press with hold_done=0 is discarded, not queued. Hits are ignored.
  - The hold counter clears to 0 in every cycle the state is not END.
  - Any non-one-hot state value -> START on the next edge. game_rst_pulse is not asserted for this recovery.
- game_rst_pulse:
  - Registered.
  - High exactly in the first cycle Game_status==010.
  - Low otherwise, including in every cycle the state stays PLAY.
- Outputs never change except on Clk_40mhz rising edges or on async reset assertion.

Decomposition:
- Shared package game_pkg: localparams ST_START=3'b001, ST_PLAY=3'b010, ST_END=3'b100, and STATUS_W=3. The VGA select logic uses the same constants.
- One sub-module, key_debounce, containing the synchroniser, the debounce counter and the press-strobe generator.
  - Parameters: DEBOUNCE_CYCLES, CNT_W.
  - Ports: Clk_40mhz, RSTn, key_n, key_press.
- The FSM and hold counter stay in game_status_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, END_HOLD_CYCLES=10, CNT_W=4):
- Reset: hold RSTn=0 for 3 cycles, then release -> Game_status=001, game_rst_pulse=0, key_press=0. Drive RSTn=0 mid-PLAY -> Game_status=001 immediately, without waiting for a clock edge.
- Clean press: in START drive key_start_n 1->0 and hold -> key_press high for exactly 1 cycle, 7 cycles after the edge. Game_status=010 and game_rst_pulse=1 on the next cycle. game_rst_pulse=0 on the cycle after that.
- Bounce rejection: toggle key_start_n 0/1 every 2 cycles for 20 cycles -> no key_press, and Game_status stays 001.
- Collision: in PLAY pulse hit_body for 1 cycle -> Game_status=100 on the next cycle. Repeat with hit_wall and key_press in the same cycle -> 100.
- End hold: enter END and produce a debounced key_press 5 cycles later -> stays 100. A key_press 12 cycles after entry -> Game_status=001 on the next cycle, with game_rst_pulse=0.
- Illegal state: force the state register to 3'b011 -> Game_status=001 on the next edge, with game_rst_pulse=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-flow definitions.
// Purpose : one-hot Game_status encodings, also used by the VGA screen
//           selector, plus the FSM state type built from them.
// Ports   : none (package).
package game_pkg;

    localparam int STATUS_W = 3;

    localparam logic [STATUS_W-1:0] ST_START = 3'b001;
    localparam logic [STATUS_W-1:0] ST_PLAY  = 3'b010;
    localparam logic [STATUS_W-1:0] ST_END   = 3'b100;

    // The state register drives Game_status directly, so the enum
    // encoding is the one-hot bus encoding.
    typedef enum logic [STATUS_W-1:0] {
        S_START = ST_START,
        S_PLAY  = ST_PLAY,
        S_END   = ST_END
    } state_e;

endpackage

// File: rtl/key_debounce.sv
// Start-key conditioning.
// Purpose : synchronise the raw active-low push-button, debounce it and
//           emit a one-cycle strobe for each accepted press.
// Ports   : Clk_40mhz - system clock
//           RSTn      - asynchronous active-low reset
//           key_n     - raw active-low key, asynchronous and bouncy
//           key_press - registered one-cycle press strobe
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 800000,
    parameter int CNT_W           = 27
) (
    input  logic Clk_40mhz,
    input  logic RSTn,
    input  logic key_n,
    output logic key_press
);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             stable_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q;

    // Counter runs only while the synchronised level disagrees with the
    // accepted level; any agreement restarts the qualification window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk_40mhz or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            stable_q      <= 1'b1;
            stable_prev_q <= 1'b1;
            cnt_q         <= '0;
            press_q       <= 1'b0;
        end else begin
            sync1_q       <= key_n;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
            // Strobe follows the cycle in which the accepted level fell;
            // releases are silent.
            press_q       <= stable_prev_q & ~stable_q;
        end
    end

    assign key_press = press_q;

endmodule

// File: rtl/game_status_ctrl.sv
// Game-flow controller.
// Purpose : sequence START -> PLAY -> END -> START, enforce a minimum
//           end-screen hold and pulse a reinit to the snake/score logic
//           on every entry to PLAY.
// Ports   : Clk_40mhz      - system clock
//           RSTn           - asynchronous active-low reset
//           key_start_n    - raw active-low start key
//           hit_wall       - one-cycle collision pulse (wall)
//           hit_body       - one-cycle collision pulse (body)
//           Game_status    - one-hot state, registered
//           game_rst_pulse - one cycle high on first PLAY cycle
//           key_press      - debounced press strobe
module game_status_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 800000,
    parameter int END_HOLD_CYCLES = 80000000,
    parameter int CNT_W           = 27
) (
    input  logic                Clk_40mhz,
    input  logic                RSTn,
    input  logic                key_start_n,
    input  logic                hit_wall,
    input  logic                hit_body,
    output logic [STATUS_W-1:0] Game_status,
    output logic                game_rst_pulse,
    output logic                key_press
);

    state_e           state_q, state_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             hold_done;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_key (
        .Clk_40mhz(Clk_40mhz),
        .RSTn     (RSTn),
        .key_n    (key_start_n),
        .key_press(key_press)
    );

    // Hold counter: counts up in END, saturates, cleared elsewhere.
    assign hold_done = (hold_q == CNT_W'(END_HOLD_CYCLES - 1));

    always_comb begin
        hold_d = '0;
        if (state_q == S_END)
            hold_d = hold_done ? hold_q : hold_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        case (state_q)
            S_START: begin
                if (key_press) begin
                    state_d = S_PLAY;
                    pulse_d = 1'b1;
                end
            end
            S_PLAY: begin
                // A hit wins over a simultaneous press.
                if (hit_wall | hit_body)
                    state_d = S_END;
            end
            S_END: begin
                // Early presses are dropped, not remembered.
                if (key_press && hold_done)
                    state_d = S_START;
            end
            // Corrupted encodings fall back silently, no reinit pulse.
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge Clk_40mhz or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_START;
            pulse_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            hold_q  <= hold_d;
        end
    end

    assign Game_status    = state_q;
    assign game_rst_pulse = pulse_q;

endmodule

// File: tb/tb_game_status_ctrl.sv
module tb_game_status_ctrl;

    localparam int D = 4;
    localparam int H = 10;

    logic       Clk_40mhz = 1'b0;
    logic       RSTn;
    logic       key_start_n;
    logic       hit_wall;
    logic       hit_body;
    logic [2:0] Game_status;
    logic       game_rst_pulse;
    logic       key_press;

    int ntot  = 0;
    int npass = 0;

    // Reference model state.
    logic h[$];        // raw key samples, newest first
    logic m_stable, m_pend, m_press, m_pulse;
    int   m_state;     // 0 START, 1 PLAY, 2 END
    int   m_age;       // cycles spent in END
    bit   m_illegal;

    game_status_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .END_HOLD_CYCLES(H),
        .CNT_W          (4)
    ) dut (
        .Clk_40mhz     (Clk_40mhz),
        .RSTn          (RSTn),
        .key_start_n   (key_start_n),
        .hit_wall      (hit_wall),
        .hit_body      (hit_body),
        .Game_status   (Game_status),
        .game_rst_pulse(game_rst_pulse),
        .key_press     (key_press)
    );

    always #5 Clk_40mhz = ~Clk_40mhz;

    task automatic chk(input string tag, input logic [2:0] act, input logic [2:0] exp);
        ntot++;
        assert (act === exp) npass++;
        else $error("FAIL %s: observed %0b expected %0b", tag, act, exp);
    endtask

    task automatic reset_model();
        h.delete();
        for (int i = 0; i < D + 2; i++) h.push_back(1'b1);
        m_stable = 1'b1; m_pend = 1'b0; m_press = 1'b0; m_pulse = 1'b0;
        m_state = 0; m_age = 0; m_illegal = 0;
    endtask

    function automatic logic [2:0] m_status();
        return 3'(1 << m_state);
    endfunction

    // One clock edge of the specification's rules.
    task automatic model_edge(input logic k, input logic hw, input logic hb);
        bit   flip;
        int   n_state, n_age;
        logic n_pulse;
        // Accept a new level once the synchronised key (raw delayed two
        // edges) has shown the opposite level for D consecutive samples.
        flip = 1;
        for (int i = 1; i <= D; i++) if (h[i] == m_stable) flip = 0;
        n_state = m_state; n_age = m_age; n_pulse = 1'b0;
        if (m_illegal) begin
            n_state = 0; m_illegal = 0;
        end else begin
            case (m_state)
                0: if (m_press) begin n_state = 1; n_pulse = 1'b1; end
                1: if (hw | hb) begin n_state = 2; n_age = 0; end
                default: if (m_press && m_age >= H - 1) n_state = 0;
                         else n_age = m_age + 1;
            endcase
        end
        m_press = m_pend;
        m_pend  = flip && m_stable;
        if (flip) m_stable = ~m_stable;
        h.push_front(k);
        void'(h.pop_back());
        m_state = n_state; m_age = n_age; m_pulse = n_pulse;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".status"}, Game_status, m_status());
        chk({tag, ".pulse"}, {2'b0, game_rst_pulse}, {2'b0, m_pulse});
        chk({tag, ".press"}, {2'b0, key_press}, {2'b0, m_press});
    endtask

    task automatic step(input logic k, input logic hw, input logic hb, input string tag);
        key_start_n = k; hit_wall = hw; hit_body = hb;
        @(posedge Clk_40mhz);
        model_edge(k, hw, hb);
        @(negedge Clk_40mhz);
        check_all(tag);
    endtask

    task automatic hold_key(input logic k, input int n, input string tag);
        for (int i = 0; i < n; i++) step(k, 1'b0, 1'b0, tag);
    endtask

    // Hold the key down until the debounced strobe shows (bounded).
    task automatic press_and_wait(input string tag);
        bit seen = 0;
        for (int i = 0; i < 15 && !seen; i++) begin
            step(1'b0, 1'b0, 1'b0, tag);
            seen = key_press;
        end
        chk({tag, ".seen"}, {2'b0, key_press}, 3'b001);
    endtask

    initial begin
        int first;
        RSTn = 1'b0; key_start_n = 1'b1; hit_wall = 1'b0; hit_body = 1'b0;
        reset_model();
        repeat (3) @(posedge Clk_40mhz);
        @(negedge Clk_40mhz);
        RSTn = 1'b1;
        check_all("reset");

        // Bounce: 2-cycle toggles never qualify, with hits ignored in START.
        for (int i = 0; i < 20; i++)
            step(((i / 2) % 2) == 1, i == 5, i == 9, "bounce");
        hold_key(1'b1, 6, "settle");
        chk("bounce.status", Game_status, 3'b001);

        // Clean press: strobe 7 cycles after the edge, then PLAY + pulse.
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0, 1'b0, "clean");
            if (key_press && first == 0) first = i;
        end
        chk("clean.latency", 3'(first), 3'd7);
        chk("clean.play", Game_status, 3'b010);

        // Release in PLAY gives no strobe; hit_body ends the game.
        hold_key(1'b1, 8, "release");
        step(1'b1, 1'b0, 1'b1, "hit_body");
        chk("hit_body.end", Game_status, 3'b100);

        // Early press in END is discarded, later one returns to START.
        hold_key(1'b0, 10, "early");
        chk("early.stay", Game_status, 3'b100);
        hold_key(1'b1, 8, "rel2");
        hold_key(1'b0, 10, "late");
        chk("late.start", Game_status, 3'b001);

        // Back to PLAY, then hit_wall coincident with a press.
        hold_key(1'b1, 8, "rel3");
        press_and_wait("enter");
        step(1'b0, 1'b0, 1'b0, "enter.play");
        hold_key(1'b1, 8, "rel4");
        press_and_wait("coinc");
        step(1'b0, 1'b1, 1'b0, "hit_wall");
        chk("hit_wall.end", Game_status, 3'b100);

        // Corrupt the state register; it must recover to START silently.
        key_start_n = 1'b0;
        force dut.state_q = game_pkg::state_e'(3'b011);
        @(posedge Clk_40mhz);
        m_illegal = 1;
        model_edge(1'b0, 1'b0, 1'b0);
        #1 release dut.state_q;
        @(negedge Clk_40mhz);
        chk("illegal.pulse", {2'b0, game_rst_pulse}, 3'b000);
        step(1'b0, 1'b0, 1'b0, "illegal");
        chk("illegal.start", Game_status, 3'b001);

        // Async reset mid-PLAY acts before any clock edge.
        hold_key(1'b1, 8, "rel5");
        press_and_wait("enter2");
        step(1'b1, 1'b0, 1'b0, "enter2.play");
        chk("enter2.status", Game_status, 3'b010);
        #2 RSTn = 1'b0;
        #1 chk("async.status", Game_status, 3'b001);
        chk("async.pulse", {2'b0, game_rst_pulse}, 3'b000);
        chk("async.press", {2'b0, key_press}, 3'b000);
        reset_model();
        @(posedge Clk_40mhz);
        @(negedge Clk_40mhz);
        RSTn = 1'b1;
        check_all("async.rel");

        // Randomised key runs and sparse hits against the model.
        for (int s = 0; s < 60; s++) begin
            logic k;
            int   len;
            k   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++)
                step(k, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, "rand");
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
